// File: rtl/dp_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, FSM state encoding,
// one-hot select constants, ALU op codes and the bundled strobe struct.
package dp_pkg;

    // Micro-instruction opcodes (instr[7:5])
    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_STT = 3'b110;
    localparam logic [2:0] OP_STA = 3'b111;

    // Register-file write source (one-hot)
    localparam logic [2:0] SR_IN  = 3'b001;
    localparam logic [2:0] SR_ALU = 3'b010;
    localparam logic [2:0] SR_TMP = 3'b100;

    // tmp load source (one-hot)
    localparam logic [2:0] TSEL_ALU = 3'b001;
    localparam logic [2:0] TSEL_R0  = 3'b010;
    localparam logic [2:0] TSEL_B   = 3'b100;

    // ALU operation select
    localparam logic [1:0] ALU_XOR  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_SHL  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } dp_state_t;

    // Every datapath strobe/select in one bundle
    typedef struct packed {
        logic       w;
        logic [1:0] rn;
        logic [2:0] sr;
        logic [1:0] aluop;
        logic       lt;
        logic [2:0] tsel;
        logic [2:0] bsel;
    } dp_ctrl_t;

    // Rm selects the B operand; Rm=00 means a zero operand (no register selected)
    function automatic logic [2:0] bsel_from_rm(input logic [1:0] rm);
        case (rm)
            2'b01:   bsel_from_rm = 3'b001;
            2'b10:   bsel_from_rm = 3'b010;
            2'b11:   bsel_from_rm = 3'b100;
            default: bsel_from_rm = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/dp_seq_decode.sv
// Pure combinational decode of a latched micro-instruction into datapath
// strobes. When en is low every strobe sits at its inactive default.
module dp_seq_decode
    import dp_pkg::*;
(
    input  logic       en,
    input  logic [2:0] op,
    input  logic [1:0] rd,
    input  logic [1:0] rm,
    output dp_ctrl_t   ctrl
);

    // Strobe decode: defaults first, then per-opcode overrides while executing
    always_comb begin
        ctrl = '0;
        if (en) begin
            ctrl.bsel = bsel_from_rm(rm);
            case (op)
                OP_LDI: begin
                    ctrl.w  = 1'b1;
                    ctrl.rn = rd;
                    ctrl.sr = SR_IN;
                end
                OP_MVT: begin
                    ctrl.lt   = 1'b1;
                    ctrl.tsel = TSEL_R0;
                end
                OP_LDB: begin
                    ctrl.lt   = 1'b1;
                    ctrl.tsel = TSEL_B;
                end
                OP_XOR: begin
                    ctrl.lt    = 1'b1;
                    ctrl.tsel  = TSEL_ALU;
                    ctrl.aluop = ALU_XOR;
                end
                OP_AND: begin
                    ctrl.lt    = 1'b1;
                    ctrl.tsel  = TSEL_ALU;
                    ctrl.aluop = ALU_AND;
                end
                OP_SHL: begin
                    ctrl.lt    = 1'b1;
                    ctrl.tsel  = TSEL_ALU;
                    ctrl.aluop = ALU_SHL;
                end
                OP_STT: begin
                    ctrl.w  = 1'b1;
                    ctrl.rn = rd;
                    ctrl.sr = SR_TMP;
                end
                OP_STA: begin
                    ctrl.w     = 1'b1;
                    ctrl.rn    = rd;
                    ctrl.sr    = SR_ALU;
                    ctrl.aluop = ALU_PASS;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dp_sequencer.sv
// Control sequencer for the 8-bit register/tmp datapath. Accepts one
// micro-instruction per start handshake, runs it for one or more EXEC cycles
// (SHL repeats Rm+1 times) and pulses done in the following DONE cycle.
// Optional build macro DP_SEQ_PREFETCH_EN adds a one-entry instruction buffer
// so a new op can be accepted while one is in flight.
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int SHIFT_CW = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr,
    output logic       ready,
    output logic       done,
    output logic       w,
    output logic [1:0] Rn,
    output logic [2:0] sr,
    output logic [1:0] aluop,
    output logic       lt,
    output logic [2:0] tsel,
    output logic [2:0] bsel
);

    // Handshake: an instruction transfers on a rising clk edge where both
    // start and ready are high; start without ready is simply dropped, and
    // ready never depends combinationally on start.

    // Latched instruction keeps only {op, Rd, Rm}; bit 0 is reserved
    dp_state_t             state_q, state_d;
    logic [6:0]            instr_q, instr_d;
    logic [SHIFT_CW-1:0]   cnt_q, cnt_d;
    logic                  accept;
    logic                  unused_instr_bit;
    dp_ctrl_t              ctrl;

    assign unused_instr_bit = instr[0];
    assign accept           = start & ready;

`ifdef DP_SEQ_PREFETCH_EN
    logic       buf_valid_q, buf_valid_d;
    logic [6:0] buf_instr_q, buf_instr_d;

    assign ready = ~buf_valid_q;
`else
    assign ready = (state_q == ST_IDLE);
`endif

    assign done = (state_q == ST_DONE);

    // Next-state, instruction latch and shift repeat counter
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
`ifdef DP_SEQ_PREFETCH_EN
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DP_SEQ_PREFETCH_EN
                // A buffered op (taken during the previous DONE) goes first
                if (buf_valid_q) begin
                    state_d     = ST_EXEC;
                    instr_d     = buf_instr_q;
                    cnt_d       = SHIFT_CW'(buf_instr_q[1:0]);
                    buf_valid_d = 1'b0;
                end else if (accept) begin
                    state_d = ST_EXEC;
                    instr_d = instr[7:1];
                    cnt_d   = SHIFT_CW'(instr[2:1]);
                end
`else
                if (accept) begin
                    state_d = ST_EXEC;
                    instr_d = instr[7:1];
                    cnt_d   = SHIFT_CW'(instr[2:1]);
                end
`endif
            end
            ST_EXEC: begin
                // Only SHL repeats; the counter stops at zero
                if ((cnt_q == '0) || (instr_q[6:4] != OP_SHL)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - SHIFT_CW'(1);
                end
`ifdef DP_SEQ_PREFETCH_EN
                if (accept) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = instr[7:1];
                end
`endif
            end
            ST_DONE: begin
`ifdef DP_SEQ_PREFETCH_EN
                // Back-to-back: skip IDLE when an op is already waiting
                if (buf_valid_q) begin
                    state_d     = ST_EXEC;
                    instr_d     = buf_instr_q;
                    cnt_d       = SHIFT_CW'(buf_instr_q[1:0]);
                    buf_valid_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    if (accept) begin
                        buf_valid_d = 1'b1;
                        buf_instr_d = instr[7:1];
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, instruction and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DP_SEQ_PREFETCH_EN
    // Prefetch buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
        end
    end
`endif

    // Strobes are decoded only from registered state and latched instr
    dp_seq_decode u_decode (
        .en   (state_q == ST_EXEC),
        .op   (instr_q[6:4]),
        .rd   (instr_q[3:2]),
        .rm   (instr_q[1:0]),
        .ctrl (ctrl)
    );

    assign w     = ctrl.w;
    assign Rn    = ctrl.rn;
    assign sr    = ctrl.sr;
    assign aluop = ctrl.aluop;
    assign lt    = ctrl.lt;
    assign tsel  = ctrl.tsel;
    assign bsel  = ctrl.bsel;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed testbench for dp_sequencer. Optional macro DP_SEQ_PREFETCH_EN
// selects the prefetch-buffer scenario in place of the held-start scenario.
module tb_dp_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] instr;
    logic       ready;
    logic       done;
    logic       w;
    logic [1:0] Rn;
    logic [2:0] sr;
    logic [1:0] aluop;
    logic       lt;
    logic [2:0] tsel;
    logic [2:0] bsel;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected done-pulse cycle indices
    logic [15:0] exp_q[$];

`ifdef DP_SEQ_PREFETCH_EN
    localparam logic RDY_BUSY = 1'b1;
`else
    localparam logic RDY_BUSY = 1'b0;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dp_sequencer #(.SHIFT_CW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .instr (instr),
        .ready (ready),
        .done  (done),
        .w     (w),
        .Rn    (Rn),
        .sr    (sr),
        .aluop (aluop),
        .lt    (lt),
        .tsel  (tsel),
        .bsel  (bsel)
    );

    // Observed strobes packed as {w, Rn, sr, aluop, lt, tsel, bsel}
    logic [14:0] ctrl_obs;
    assign ctrl_obs = {w, Rn, sr, aluop, lt, tsel, bsel};

    function automatic logic [14:0] ctl(input logic cw, input logic [1:0] crn,
                                        input logic [2:0] csr, input logic [1:0] calu,
                                        input logic clt, input logic [2:0] ctsel,
                                        input logic [2:0] cbsel);
        ctl = {cw, crn, csr, calu, clt, ctsel, cbsel};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Advance one edge and settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ins);
        start = 1'b1;
        instr = ins;
        tick();
        start = 1'b0;
    endtask

    // Single-cycle op table: instruction and expected EXEC strobes
    logic [7:0]  op_ins [7];
    logic [14:0] op_exp [7];

    initial begin
        logic [14:0] shl3;
        int n_exec;
        int n_ready;
        int n_w;

        op_ins[0] = 8'b000_10_00_0; op_exp[0] = ctl(1, 2'b10, 3'b001, 2'b00, 0, 3'b000, 3'b000); // LDI
        op_ins[1] = 8'b111_01_00_0; op_exp[1] = ctl(1, 2'b01, 3'b010, 2'b11, 0, 3'b000, 3'b000); // STA Rm=0
        op_ins[2] = 8'b010_00_10_0; op_exp[2] = ctl(0, 2'b00, 3'b000, 2'b00, 1, 3'b100, 3'b010); // LDB Rm=2
        op_ins[3] = 8'b001_00_00_0; op_exp[3] = ctl(0, 2'b00, 3'b000, 2'b00, 1, 3'b010, 3'b000); // MVT
        op_ins[4] = 8'b011_00_01_1; op_exp[4] = ctl(0, 2'b00, 3'b000, 2'b00, 1, 3'b001, 3'b001); // XOR Rm=1
        op_ins[5] = 8'b100_00_10_0; op_exp[5] = ctl(0, 2'b00, 3'b000, 2'b01, 1, 3'b001, 3'b010); // AND Rm=2
        op_ins[6] = 8'b110_11_11_0; op_exp[6] = ctl(1, 2'b11, 3'b100, 2'b00, 0, 3'b000, 3'b100); // STT Rd=3
        shl3      = ctl(0, 2'b00, 3'b000, 2'b10, 1, 3'b001, 3'b100);

        // ---------------- reset ----------------
        reset = 1'b1;
        start = 1'b0;
        instr = 8'h00;
        tick();
        tick();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_ctrl", ctrl_obs, 0);
        reset = 1'b0;
        tick();

        // ---------------- single-cycle ops ----------------
        for (int i = 0; i < 7; i++) begin
            issue(op_ins[i]);
            check($sformatf("op%0d_exec_ctrl", i), ctrl_obs, op_exp[i]);
            check($sformatf("op%0d_exec_done", i), done, 0);
            check($sformatf("op%0d_exec_ready", i), ready, RDY_BUSY);
            tick();
            check($sformatf("op%0d_done", i), done, 1);
            check($sformatf("op%0d_done_ctrl", i), ctrl_obs, 0);
            tick();
            check($sformatf("op%0d_idle_ready", i), ready, 1);
            check($sformatf("op%0d_idle_done", i), done, 0);
        end

        // ---------------- SHL Rm=3: four EXEC cycles ----------------
        issue(8'b101_00_11_0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("shl_exec%0d_ctrl", i), ctrl_obs, shl3);
            check($sformatf("shl_exec%0d_done", i), done, 0);
            tick();
        end
        check("shl_done", done, 1);
        check("shl_done_ctrl", ctrl_obs, 0);
        tick();
        check("shl_idle_ready", ready, 1);
        check("shl_idle_done", done, 0);

        // ---------------- reset during SHL EXEC ----------------
        issue(8'b101_00_11_0);
        check("rmid_exec_ctrl", ctrl_obs, shl3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_ready", ready, 1);
        check("rmid_done", done, 0);
        check("rmid_ctrl", ctrl_obs, 0);
        n_exec = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) n_exec++;
            if (ctrl_obs != 0) n_exec++;
        end
        check("rmid_no_activity", n_exec, 0);

`ifndef DP_SEQ_PREFETCH_EN
        // ---------------- start held through three SHL Rm=1 ops ----------------
        // Each op: EXEC x2, DONE, IDLE -> done at cycles 3, 7, 11
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd7);
        exp_q.push_back(16'd11);
        n_exec  = 0;
        n_ready = 0;
        n_w     = 0;
        start   = 1'b1;
        instr   = 8'b101_00_01_0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done) begin
                if (exp_q.size() == 0) check("hold_done_extra", k, 0);
                else check("hold_done_cycle", k, exp_q.pop_front());
            end
            if (lt) begin
                n_exec++;
                check($sformatf("hold_exec_ctrl_c%0d", k), ctrl_obs,
                      ctl(0, 2'b00, 3'b000, 2'b10, 1, 3'b001, 3'b001));
            end
            if (ready) n_ready++;
            if (w) n_w++;
            // Swap in an LDI while busy; it must never be taken
            if (k == 1) instr = 8'b000_11_00_0;
            if (k == 3) instr = 8'b101_00_01_0;
        end
        start = 1'b0;
        check("hold_done_missing", exp_q.size(), 0);
        check("hold_exec_cycles", n_exec, 6);
        check("hold_ready_cycles", n_ready, 3);
        check("hold_ignored_ldi", n_w, 0);
        tick();
        tick();
        check("hold_end_idle", ready, 1);
`else
        // ---------------- prefetch: back-to-back via buffer ----------------
        issue(8'b000_10_00_0);                      // LDI enters EXEC
        check("pf_op1_exec", ctrl_obs, op_exp[0]);
        check("pf_op1_ready", ready, 1);
        start = 1'b1;
        instr = 8'b111_01_00_0;                     // STA taken into buffer
        tick();
        check("pf_op1_done", done, 1);
        check("pf_buf_full_ready", ready, 0);
        instr = 8'b001_00_00_0;                     // MVT offered while full
        tick();
        start = 1'b0;
        check("pf_op2_exec", ctrl_obs, op_exp[1]);
        check("pf_op2_ready", ready, 1);
        tick();
        check("pf_op2_done", done, 1);
        tick();
        check("pf_idle_ready", ready, 1);
        check("pf_idle_ctrl", ctrl_obs, 0);
        tick();
        check("pf_third_ignored", ctrl_obs, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
